line_fill_unit: RTL and testbench

//  Miss-refill engine directly upstream of the cache data array. On a controller

---
 rtl/cache_pkg.sv | 37 +++
 rtl/fill_buffer.sv | 28 ++
 rtl/line_fill_unit.sv | 117 +++++++++++
 tb/tb_line_fill_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache configuration: default geometry, refill FSM encodings and
// address field helpers used by the tag array, data array and line fill unit.
package cache_pkg;

    localparam int CACHE_ADDR_W   = 32;
    localparam int CACHE_BLOCK_W  = 128;
    localparam int CACHE_WORD_W   = 32;
    localparam int CACHE_INDEX_W  = 10;
    localparam int CACHE_OFFSET_W = 4;

    localparam int CACHE_BEATS  = CACHE_BLOCK_W / CACHE_WORD_W;
    localparam int CACHE_BYTE_W = $clog2(CACHE_WORD_W / 8);
    localparam int CACHE_WSEL_W = CACHE_OFFSET_W - CACHE_BYTE_W;
    localparam int CACHE_TAG_W  = CACHE_ADDR_W - CACHE_INDEX_W - CACHE_OFFSET_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RECV  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    function automatic logic [CACHE_TAG_W-1:0] addr_tag(input logic [CACHE_ADDR_W-1:0] a);
        return a[CACHE_ADDR_W-1 -: CACHE_TAG_W];
    endfunction

    function automatic logic [CACHE_INDEX_W-1:0] addr_index(input logic [CACHE_ADDR_W-1:0] a);
        return a[CACHE_OFFSET_W +: CACHE_INDEX_W];
    endfunction

    function automatic logic [CACHE_OFFSET_W-1:0] addr_offset(input logic [CACHE_ADDR_W-1:0] a);
        return a[CACHE_OFFSET_W-1:0];
    endfunction

    function automatic logic [CACHE_WSEL_W-1:0] addr_wsel(input logic [CACHE_ADDR_W-1:0] a);
        return a[CACHE_BYTE_W +: CACHE_WSEL_W];
    endfunction

endpackage

// File: rtl/fill_buffer.sv
// Line assembly buffer: BEATS word slots, each with its own write enable,
// presented as one flat line (slot w at [w*WORD_WIDTH +: WORD_WIDTH]).
module fill_buffer #(
    parameter int BEATS      = 4,
    parameter int WORD_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [BEATS-1:0]            we_i,
    input  logic [WORD_WIDTH-1:0]       wdata_i,
    output logic [BEATS*WORD_WIDTH-1:0] data_o
);

    logic [BEATS-1:0][WORD_WIDTH-1:0] slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            for (int w = 0; w < BEATS; w++) begin
                if (we_i[w]) slot_q[w] <= wdata_i;
            end
        end
    end

    assign data_o = slot_q;

endmodule

// File: rtl/line_fill_unit.sv
// Miss refill engine: issues one wrapping burst read, assembles the line,
// forwards the critical word early and writes the line to the data array.
module line_fill_unit
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH   = CACHE_ADDR_W,
    parameter int BLOCK_WIDTH  = CACHE_BLOCK_W,
    parameter int WORD_WIDTH   = CACHE_WORD_W,
    parameter int INDEX_WIDTH  = CACHE_INDEX_W,
    parameter int OFFSET_WIDTH = CACHE_OFFSET_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   miss_req_i,
    input  logic [ADDR_WIDTH-1:0]  miss_addr_i,
    output logic                   fill_busy_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr_o,
    input  logic                   mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0]  mem_rdata_i,
    input  logic                   mem_rlast_i,
    input  logic                   mem_rerr_i,
    output logic                   crit_valid_o,
    output logic [WORD_WIDTH-1:0]  crit_data_o,
    output logic                   refill_o,
    output logic [INDEX_WIDTH-1:0] fill_index_o,
    output logic [BLOCK_WIDTH-1:0] data_block_o,
    output logic                   fill_err_o
);

    localparam int BEATS  = BLOCK_WIDTH / WORD_WIDTH;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int BYTE_W = $clog2(WORD_WIDTH / 8);
    localparam int WADR_W = ADDR_WIDTH - BYTE_W;

    logic [1:0]        state_q, state_d;
    logic [WADR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q, err_d;

    logic              beat, last_cnt, beat_bad;
    logic [CNT_W-1:0]  wsel, slot;
    logic [BEATS-1:0]  slot_we;
    logic              unused_byte;

    // Byte lanes never reach memory; the request is word aligned.
    assign unused_byte = ^miss_addr_i[BYTE_W-1:0];

    assign wsel     = addr_q[OFFSET_WIDTH-BYTE_W-1:0];
    assign slot     = wsel + cnt_q;
    assign beat     = (state_q == ST_RECV) && mem_rvalid_i;
    assign last_cnt = (cnt_q == CNT_W'(BEATS - 1));
    // rlast must coincide exactly with the final beat: early or missing both abort.
    assign beat_bad = mem_rerr_i || (mem_rlast_i != last_cnt);
    assign slot_we  = beat ? (BEATS'(1) << slot) : '0;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (miss_req_i) state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready_i) state_d = ST_RECV;
            ST_RECV: begin
                if (beat) begin
                    if (beat_bad) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else if (last_cnt) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == ST_IDLE && miss_req_i) begin
                addr_q <= miss_addr_i[ADDR_WIDTH-1:BYTE_W];
                cnt_q  <= '0;
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    fill_buffer #(
        .BEATS      (BEATS),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (slot_we),
        .wdata_i (mem_rdata_i),
        .data_o  (data_block_o)
    );

    assign fill_busy_o     = (state_q != ST_IDLE);
    assign mem_req_valid_o = (state_q == ST_REQ);
    assign mem_req_addr_o  = {addr_q, {BYTE_W{1'b0}}};
    // An errored first beat carries no usable data, so it is not forwarded.
    assign crit_valid_o    = beat && (cnt_q == '0) && !mem_rerr_i;
    assign crit_data_o     = crit_valid_o ? mem_rdata_i : '0;
    assign refill_o        = (state_q == ST_WRITE);
    assign fill_index_o    = addr_q[OFFSET_WIDTH-BYTE_W +: INDEX_WIDTH];
    assign fill_err_o      = err_q;

endmodule

// File: tb/tb_line_fill_unit.sv
// Directed plus randomized bench for line_fill_unit with an in-bench model of
// the wrapping burst, critical word forwarding and abort rules.
module tb_line_fill_unit;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         fill_busy, mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_req_addr;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         mem_rlast = 1'b0;
    logic         mem_rerr = 1'b0;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         refill;
    logic [9:0]   fill_index;
    logic [127:0] data_block;
    logic         fill_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    line_fill_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .miss_req_i      (miss_req),
        .miss_addr_i     (miss_addr),
        .fill_busy_o     (fill_busy),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rvalid_i    (mem_rvalid),
        .mem_rdata_i     (mem_rdata),
        .mem_rlast_i     (mem_rlast),
        .mem_rerr_i      (mem_rerr),
        .crit_valid_o    (crit_valid),
        .crit_data_o     (crit_data),
        .refill_o        (refill),
        .fill_index_o    (fill_index),
        .data_block_o    (data_block),
        .fill_err_o      (fill_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One miss from request to completion. last_beat: beat index carrying rlast
    // (>3 means never); err_beat: beat carrying rerr (-1 none); abort_at: beat
    // index at which rst_n is pulled low instead (-1 none).
    task automatic do_fill(input logic [31:0] addr, input int rdy_dly, input int err_beat,
                           input int last_beat, input bit hold, input int max_gap,
                           input int abort_at);
        logic [31:0]  w [4];
        logic [127:0] exp_blk;
        int           wsel, end_beat, cyc;
        bit           ok;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        wsel     = int'(addr[3:2]);
        exp_blk  = '0;
        for (int i = 0; i < 4; i++) exp_blk[((wsel + i) % 4) * 32 +: 32] = w[i];
        end_beat = 3;
        ok       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == err_beat || (i == last_beat && i != 3) || (i == 3 && last_beat != 3)) begin
                end_beat = i;
                ok       = 1'b0;
                break;
            end
        end

        @(posedge clk); #1;
        miss_req  = 1'b1;
        miss_addr = addr;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!mem_req_valid && cyc < 20);
        chk("req_valid", mem_req_valid, 1'b1);
        chk("req_addr", mem_req_addr, {addr[31:2], 2'b00});
        chk("busy_req", fill_busy, 1'b1);
        if (!hold) begin
            miss_req  = 1'b0;
            miss_addr = $urandom;
        end
        for (int k = 0; k < rdy_dly; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", mem_req_valid, 1'b1);
            chk("stall_addr", mem_req_addr, {addr[31:2], 2'b00});
        end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        chk("recv_noreq", mem_req_valid, 1'b0);

        for (int i = 0; i <= end_beat; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
            if (i == abort_at) begin
                mem_rvalid = 1'b1;
                mem_rdata  = w[i];
                rst_n      = 1'b0;
                #1;
                chk("rst_refill", refill, 1'b0);
                chk("rst_crit", crit_valid, 1'b0);
                chk("rst_busy", fill_busy, 1'b0);
                chk("rst_reqv", mem_req_valid, 1'b0);
                chk("rst_block", data_block, 128'd0);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                repeat (2) begin
                    @(posedge clk); #1;
                    mem_rdata = $urandom;
                    #1;
                    chk("post_rst_busy", fill_busy, 1'b0);
                    chk("post_rst_crit", crit_valid, 1'b0);
                end
                mem_rvalid = 1'b0;
                return;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = w[i];
            mem_rlast  = (i == last_beat);
            mem_rerr   = (i == err_beat);
            #1;
            if (i == 0 && i != err_beat) begin
                chk("crit_valid", crit_valid, 1'b1);
                chk("crit_data", crit_data, w[0]);
            end else begin
                chk("crit_quiet", crit_valid, 1'b0);
            end
            chk("no_second_req", mem_req_valid, 1'b0);
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
            mem_rerr   = 1'b0;
            mem_rdata  = $urandom;
        end

        if (ok) begin
            chk("refill", refill, 1'b1);
            chk("data_block", data_block, exp_blk);
            chk("fill_index", fill_index, addr[13:4]);
            chk("no_err", fill_err, 1'b0);
            @(posedge clk); #1;
            chk("refill_pulse", refill, 1'b0);
            chk("idle_busy", fill_busy, 1'b0);
        end else begin
            chk("fill_err", fill_err, 1'b1);
            chk("err_norefill", refill, 1'b0);
            chk("err_busy", fill_busy, 1'b0);
            @(posedge clk); #1;
            chk("err_pulse", fill_err, 1'b0);
            chk("err_norefill2", refill, 1'b0);
        end
    endtask

    initial begin
        #2;
        chk("reset_busy", fill_busy, 1'b0);
        chk("reset_reqv", mem_req_valid, 1'b0);
        chk("reset_refill", refill, 1'b0);
        chk("reset_crit", {crit_valid, crit_data}, 33'd0);
        chk("reset_index", fill_index, 10'd0);
        chk("reset_block", data_block, 128'd0);
        chk("reset_err", fill_err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_fill(32'h0000_1230, 0, -1, 3, 1'b0, 0, -1);   // aligned, ready first cycle
        do_fill(32'h0000_1238, 0, -1, 3, 1'b0, 0, -1);   // wrap from word 2
        do_fill(32'h0000_567C, 5, -1, 3, 1'b0, 3, -1);   // request stall + beat gaps
        do_fill(32'h0000_2224, 1, 2, 3, 1'b0, 0, -1);    // bus error on beat 2
        do_fill(32'h0000_3330, 0, -1, 1, 1'b0, 0, -1);   // rlast early on beat 1
        do_fill(32'h0000_4444, 0, -1, 9, 1'b0, 0, -1);   // rlast missing on beat 3

        // miss_req held through a fill yields exactly one follow-up fill
        do_fill(32'h0000_ABC8, 2, -1, 3, 1'b1, 1, -1);
        do_fill(32'h0000_ABC8, 0, -1, 3, 1'b0, 0, -1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_third_fill", mem_req_valid, 1'b0);
        end

        do_fill(32'h0000_7770, 0, -1, 3, 1'b0, 0, 2);    // reset after 2 beats
        do_fill(32'h0000_7774, 1, -1, 3, 1'b0, 1, -1);

        for (int n = 0; n < 12; n++) begin
            int eb;
            eb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            do_fill($urandom, int'($urandom_range(3, 0)), eb, 3, 1'b0,
                    int'($urandom_range(2, 0)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
